// File: rtl/bram_tdp_param.sv
// bram_tdp_param
// Single-clock true dual-port block RAM with per-byte write enables, a
// zero-fill clear sweep after reset, read-valid strobes and deterministic
// cross-port collision handling.
//
// Parameters:
//   DATA_WIDTH     word width (multiple of BYTE_W)
//   ADDR_WIDTH     address width, depth = 2**ADDR_WIDTH
//   BYTE_W         bits per write-enable lane
//   RD_LATENCY     1 or 2 cycles from request to dout/dout_vld
//   WRITE_FIRST    1: cross-port read sees the word being written, 0: old word
//   CLEAR_ON_RESET 1: zero-fill every location after reset before init_done
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ena/enb, wea/web                request enable, byte write enables
//                                   (we all-zero with en=1 is a read)
//   addra/addrb, dina/dinb          address, write data
//   douta/doutb, douta_vld/doutb_vld  registered read data and one-cycle valid
//   init_done                       RAM accepts requests
//   collision                       one-cycle pulse: both ports wrote one address
//
// Optional build macro BRAM_TDP_PARITY_EN adds one even-parity bit per lane
// and the outputs perr_a/perr_b, valid alongside dout_vld.
module bram_tdp_param #(
  parameter int DATA_WIDTH     = 96,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTE_W         = 8,
  parameter int RD_LATENCY     = 2,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  douta_vld,
  input  logic                  enb,
  input  logic [NB-1:0]         web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_vld,
  output logic                  init_done,
  output logic                  collision
`ifdef BRAM_TDP_PARITY_EN
  ,
  output logic                  perr_a,
  output logic                  perr_b
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc;
  logic                    clr_we;
  logic                    wr_a, wr_b, rd_a, rd_b;
  logic                    wf_hit_a, wf_hit_b;
  logic [DATA_WIDTH-1:0]   rd_word_a, rd_word_b;

  logic                    vld_a_p0, vld_b_p0;
  logic [DATA_WIDTH-1:0]   dat_a_p0, dat_b_p0;

  // Replace the lanes selected by we with the corresponding lanes of new_w.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         we
  );
    merge_lanes = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) merge_lanes[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
  endfunction

  // Control: CLEAR sweeps every address once, READY holds until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        default: init_done <= 1'b1;
      endcase
    end
  end

  // Requests are only honoured once the RAM is ready and reset is low.
  assign acc    = init_done && !rst;
  assign clr_we = (state == ST_CLEAR) && !rst;
  assign wr_a   = acc && ena && (|wea);
  assign wr_b   = acc && enb && (|web);
  assign rd_a   = acc && ena && !(|wea);
  assign rd_b   = acc && enb && !(|web);

  assign wf_hit_a = (WRITE_FIRST != 0) && wr_b && (addrb == addra);
  assign wf_hit_b = (WRITE_FIRST != 0) && wr_a && (addra == addrb);

  always_comb begin
    rd_word_a = mem[addra];
    rd_word_b = mem[addrb];
    if (wf_hit_a) rd_word_a = merge_lanes(mem[addra], dinb, web);
    if (wf_hit_b) rd_word_b = merge_lanes(mem[addrb], dina, wea);
  end

  // Storage. Port B lanes are scheduled first so that port A wins on lanes
  // both ports enable at the same address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && web[i]) mem[addrb][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a && wea[i]) mem[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage p0: array read captured. Output stage: dout updates only on a read
  // result and otherwise holds; with RD_LATENCY=1 p0 is bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_p0  <= 1'b0;
      vld_b_p0  <= 1'b0;
      dat_a_p0  <= '0;
      dat_b_p0  <= '0;
      douta     <= '0;
      doutb     <= '0;
      douta_vld <= 1'b0;
      doutb_vld <= 1'b0;
      collision <= 1'b0;
    end else begin
      vld_a_p0 <= rd_a;
      vld_b_p0 <= rd_b;
      if (rd_a) dat_a_p0 <= rd_word_a;
      if (rd_b) dat_b_p0 <= rd_word_b;
      if (RD_LATENCY == 1) begin
        douta_vld <= rd_a;
        doutb_vld <= rd_b;
        if (rd_a) douta <= rd_word_a;
        if (rd_b) doutb <= rd_word_b;
      end else begin
        douta_vld <= vld_a_p0;
        doutb_vld <= vld_b_p0;
        if (vld_a_p0) douta <= dat_a_p0;
        if (vld_b_p0) doutb <= dat_b_p0;
      end
      collision <= wr_a && wr_b && (addra == addrb);
    end
  end

`ifdef BRAM_TDP_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_rd_a, par_rd_b;
  logic          perr_now_a, perr_now_b;
  logic          perr_a_p0, perr_b_p0;

  // Even parity per lane.
  function automatic logic [NB-1:0] lane_parity(input logic [DATA_WIDTH-1:0] w);
    lane_parity = '0;
    for (int i = 0; i < NB; i++) lane_parity[i] = ^w[i*BYTE_W +: BYTE_W];
  endfunction

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && web[i]) par_mem[addrb][i] <= ^dinb[i*BYTE_W +: BYTE_W];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a && wea[i]) par_mem[addra][i] <= ^dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stored parity, merged the same way as the data on a write-first hit.
  always_comb begin
    par_rd_a = par_mem[addra];
    par_rd_b = par_mem[addrb];
    for (int i = 0; i < NB; i++) begin
      if (wf_hit_a && web[i]) par_rd_a[i] = ^dinb[i*BYTE_W +: BYTE_W];
      if (wf_hit_b && wea[i]) par_rd_b[i] = ^dina[i*BYTE_W +: BYTE_W];
    end
    perr_now_a = |(lane_parity(rd_word_a) ^ par_rd_a);
    perr_now_b = |(lane_parity(rd_word_b) ^ par_rd_b);
  end

  // Stage p0 / output stage for the parity flags, aligned with dout_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_a_p0 <= 1'b0;
      perr_b_p0 <= 1'b0;
      perr_a    <= 1'b0;
      perr_b    <= 1'b0;
    end else begin
      if (rd_a) perr_a_p0 <= perr_now_a;
      if (rd_b) perr_b_p0 <= perr_now_b;
      if (RD_LATENCY == 1) begin
        if (rd_a) perr_a <= perr_now_a;
        if (rd_b) perr_b <= perr_now_b;
      end else begin
        if (vld_a_p0) perr_a <= perr_a_p0;
        if (vld_b_p0) perr_b <= perr_b_p0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_tdp_param.sv
module tb_bram_tdp_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam int CMAX  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [DW-1:0] da [3];
  logic [DW-1:0] db [3];
  logic [2:0]    va, vb, coll, idone;

  // dut0: latency 2, read-first. dut1: latency 1, write-first. dut2: no clear.
  bram_tdp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(8), .RD_LATENCY(2),
                   .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(da[0]), .douta_vld(va[0]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(db[0]), .doutb_vld(vb[0]), .init_done(idone[0]), .collision(coll[0]));

  bram_tdp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(8), .RD_LATENCY(1),
                   .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(da[1]), .douta_vld(va[1]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(db[1]), .doutb_vld(vb[1]), .init_done(idone[1]), .collision(coll[1]));

  bram_tdp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(8), .RD_LATENCY(2),
                   .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(da[2]), .douta_vld(va[2]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(db[2]), .doutb_vld(vb[2]), .init_done(idone[2]), .collision(coll[2]));

  // Reference model: memory contents, results scheduled by the cycle they are due.
  logic [DW-1:0] mem_m [DEPTH];
  bit            rv [2][2][CMAX];
  logic [DW-1:0] rdat [2][2][CMAX];
  logic [DW-1:0] e_dout [2][2];
  bit            e_vld [2][2];
  bit            e_coll, e_init, e_init_nc;
  int            since = 0;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs presented to it.
  task automatic step();
    int n, sb;
    logic wa, wb, ra, rb;
    logic [DW-1:0] oa, ob;
    n  = cyc + 1;
    sb = since;
    if (n + 2 >= CMAX) begin
      $display("FAIL cycle_budget got cycle %0d limit %0d", n, CMAX);
      $fatal(1, "cycle budget exhausted");
    end
    wa = ena && (wea != '0);
    wb = enb && (web != '0);
    ra = ena && !wa;
    rb = enb && !wb;
    e_coll = 1'b0;
    if (!rst && sb < DEPTH) begin
      mem_m[sb] = '0;
    end else if (!rst) begin
      oa = mem_m[addra];
      ob = mem_m[addrb];
      for (int i = 0; i < NB; i++) if (wb && web[i]) mem_m[addrb][8*i +: 8] = dinb[8*i +: 8];
      for (int i = 0; i < NB; i++) if (wa && wea[i]) mem_m[addra][8*i +: 8] = dina[8*i +: 8];
      e_coll = wa && wb && (addra == addrb);
      if (ra) begin
        rv[0][0][n+1] = 1'b1; rdat[0][0][n+1] = oa;
        rv[1][0][n]   = 1'b1; rdat[1][0][n]   = mem_m[addra];
      end
      if (rb) begin
        rv[0][1][n+1] = 1'b1; rdat[0][1][n+1] = ob;
        rv[1][1][n]   = 1'b1; rdat[1][1][n]   = mem_m[addrb];
      end
    end
    if (rst) since = 0;
    else if (since < DEPTH) since++;
    e_init    = (since >= DEPTH);
    e_init_nc = (since >= 1);
    @(posedge clk);
    #1;
    cyc = n;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          e_vld[i][p]  = 1'b0;
          e_dout[i][p] = '0;
        end else begin
          e_vld[i][p] = rv[i][p][n];
          if (rv[i][p][n]) e_dout[i][p] = rdat[i][p][n];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (da[i] !== '0 || db[i] !== '0 || va[i] !== 1'b0 || vb[i] !== 1'b0 ||
          coll[i] !== 1'b0 || idone[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset dut%0d got da=%h db=%h va=%b vb=%b coll=%b init=%b want all zero",
                 i, da[i], db[i], va[i], vb[i], coll[i], idone[i]);
      end
    end
  endtask

  task automatic test_clear_sweep();
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      n_vec++;
      if (idone[0] !== (k == DEPTH) || idone[1] !== (k == DEPTH) || idone[2] !== 1'b1) begin
        n_err++;
        $display("FAIL clear_init k=%0d got %b%b%b want %b%b1", k, idone[0], idone[1], idone[2],
                 (k == DEPTH), (k == DEPTH));
      end
    end
    // back-to-back reads of every address
    for (int a = 0; a < DEPTH; a++) begin
      ena = 1'b1; addra = AW'(a);
      step();
      n_vec++;
      if (va[1] !== 1'b1 || da[1] !== '0 || va[0] !== (a != 0) || da[0] !== '0) begin
        n_err++;
        $display("FAIL clear_read a=%0d got v1=%b d1=%h v0=%b d0=%h want v1=1 d1=0 v0=%b d0=0",
                 a, va[1], da[1], va[0], da[0], (a != 0));
      end
    end
    idle();
    step();
    n_vec++;
    if (va[0] !== 1'b1 || da[0] !== '0 || va[1] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_tail got v0=%b d0=%h v1=%b want v0=1 d0=0 v1=0", va[0], da[0], va[1]);
    end
  endtask

  task automatic test_latency();
    idle();
    ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'h0000A5A5;
    step();
    idle();
    enb = 1'b1; addrb = 4'd3;
    step();
    n_vec++;
    if (vb[1] !== 1'b1 || db[1] !== 32'h0000A5A5 || vb[0] !== 1'b0) begin
      n_err++;
      $display("FAIL latency_1 got v1=%b d1=%h v0=%b want v1=1 d1=0000a5a5 v0=0", vb[1], db[1], vb[0]);
    end
    idle();
    step();
    n_vec++;
    if (vb[0] !== 1'b1 || db[0] !== 32'h0000A5A5 || vb[1] !== 1'b0 || db[1] !== 32'h0000A5A5) begin
      n_err++;
      $display("FAIL latency_2 got v0=%b d0=%h v1=%b d1=%h want 1 0000a5a5 0 0000a5a5",
               vb[0], db[0], vb[1], db[1]);
    end
  endtask

  task automatic test_byte_enables();
    idle();
    ena = 1'b1; wea = 4'hF; addra = 4'd5; dina = 32'h11223344;
    step();
    wea = 4'b0101; dina = 32'hAABBCCDD;
    step();
    n_vec++;
    if (va[0] !== 1'b0 || va[1] !== 1'b0) begin
      n_err++;
      $display("FAIL write_novld got v0=%b v1=%b want 0 0", va[0], va[1]);
    end
    wea = 4'h0;
    step();
    n_vec++;
    if (da[1] !== 32'h11BB33DD || va[1] !== 1'b1) begin
      n_err++;
      $display("FAIL byte_en_1 got %h v=%b want 11bb33dd v=1", da[1], va[1]);
    end
    idle();
    step();
    n_vec++;
    if (da[0] !== 32'h11BB33DD || va[0] !== 1'b1) begin
      n_err++;
      $display("FAIL byte_en_0 got %h v=%b want 11bb33dd v=1", da[0], va[0]);
    end
  endtask

  task automatic test_read_during_write();
    idle();
    ena = 1'b1; wea = 4'hF; addra = 4'd7; dina = 32'h1;
    step();
    dina = 32'h2; enb = 1'b1; addrb = 4'd7;
    step();
    n_vec++;
    if (db[1] !== 32'h2 || vb[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rdw_write_first got %h v=%b want 00000002 v=1", db[1], vb[1]);
    end
    idle();
    step();
    n_vec++;
    if (db[0] !== 32'h1 || vb[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rdw_read_first got %h v=%b want 00000001 v=1", db[0], vb[0]);
    end
    enb = 1'b1; addrb = 4'd7;
    step();
    idle();
    step();
    n_vec++;
    if (db[0] !== 32'h2 || db[1] !== 32'h2) begin
      n_err++;
      $display("FAIL rdw_after got d0=%h d1=%h want 00000002 00000002", db[0], db[1]);
    end
  endtask

  task automatic test_collision();
    idle();
    ena = 1'b1; wea = 4'hF; addra = 4'd9; dina = 32'hF0;
    enb = 1'b1; web = 4'hF; addrb = 4'd9; dinb = 32'h0F;
    step();
    n_vec++;
    if (coll[0] !== 1'b1 || coll[1] !== 1'b1) begin
      n_err++;
      $display("FAIL collision_pulse got %b%b want 11", coll[0], coll[1]);
    end
    idle();
    ena = 1'b1; addra = 4'd9;
    step();
    n_vec++;
    if (coll[0] !== 1'b0 || coll[1] !== 1'b0 || da[1] !== 32'hF0) begin
      n_err++;
      $display("FAIL collision_end got coll=%b%b d1=%h want 00 000000f0", coll[0], coll[1], da[1]);
    end
    // partial overlap: lane0/1 from A, lane2 from B, lane3 untouched
    ena = 1'b1; wea = 4'hF; addra = 4'd10; dina = 32'h12345678;
    step();
    n_vec++;
    if (da[0] !== 32'hF0) begin
      n_err++;
      $display("FAIL collision_read0 got %h want 000000f0", da[0]);
    end
    wea = 4'b0011; dina = 32'hAAAAAAAA;
    enb = 1'b1; web = 4'b0110; addrb = 4'd10; dinb = 32'hBBBBBBBB;
    step();
    idle();
    ena = 1'b1; addra = 4'd10;
    step();
    n_vec++;
    if (da[1] !== 32'h12BBAAAA) begin
      n_err++;
      $display("FAIL collision_lanes got %h want 12bbaaaa", da[1]);
    end
    idle();
    step();
  endtask

  task automatic test_mid_clear_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    n_vec++;
    if (idone[0] !== 1'b0 || idone[2] !== 1'b1) begin
      n_err++;
      $display("FAIL midclr_pre got init0=%b init2=%b want 0 1", idone[0], idone[2]);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if (idone[2] !== 1'b0) begin
      n_err++;
      $display("FAIL noclear_reset got %b want 0", idone[2]);
    end
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      idle();
      if (k == 11) begin
        ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h55555555;
        enb = 1'b1; addrb = 4'd2;
      end
      step();
      n_vec++;
      if (idone[0] !== (k == DEPTH) || idone[1] !== (k == DEPTH) || idone[2] !== 1'b1 ||
          vb[0] !== 1'b0 || vb[1] !== 1'b0) begin
        n_err++;
        $display("FAIL midclr k=%0d got init=%b%b%b vb=%b%b want %b%b1 00", k, idone[0], idone[1],
                 idone[2], vb[0], vb[1], (k == DEPTH), (k == DEPTH));
      end
    end
    idle();
    ena = 1'b1; addra = 4'd2;
    step();
    idle();
    step();
    n_vec++;
    if (da[0] !== '0 || da[1] !== '0 || va[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ignored_write got d0=%h d1=%h v0=%b want 0 0 1", da[0], da[1], va[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      idle();
      if (k < 1498) begin
        ena   = 1'($urandom_range(0, 1));
        enb   = 1'($urandom_range(0, 1));
        wea   = ($urandom_range(0, 1) != 0) ? NB'($urandom()) : '0;
        web   = ($urandom_range(0, 1) != 0) ? NB'($urandom()) : '0;
        addra = AW'($urandom());
        addrb = ($urandom_range(0, 3) == 0) ? addra : AW'($urandom());
        dina  = $urandom();
        dinb  = $urandom();
      end
      step();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (va[i] !== e_vld[i][0] || da[i] !== e_dout[i][0] ||
            vb[i] !== e_vld[i][1] || db[i] !== e_dout[i][1] ||
            coll[i] !== e_coll || idone[i] !== e_init) begin
          n_err++;
          $display("FAIL rand dut%0d cyc=%0d got a=%b/%h b=%b/%h c=%b i=%b want a=%b/%h b=%b/%h c=%b i=%b",
                   i, cyc, va[i], da[i], vb[i], db[i], coll[i], idone[i],
                   e_vld[i][0], e_dout[i][0], e_vld[i][1], e_dout[i][1], e_coll, e_init);
        end
      end
      n_vec++;
      if (idone[2] !== e_init_nc) begin
        n_err++;
        $display("FAIL rand_noclear_init cyc=%0d got %b want %b", cyc, idone[2], e_init_nc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_clear_sweep();
    test_latency();
    test_byte_enables();
    test_read_during_write();
    test_collision();
    test_mid_clear_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_tdp_param.md
Name: bram_tdp_param

Overview:
- Single-clock true dual-port block RAM. Successor to the fixed 96x1024 dual-port RAM.
- Generalised in data width, depth and read latency. Adds:
  - per-byte write enables
  - a hardware clear sequence after reset
  - read-valid strobes
  - deterministic cross-port collision handling
- Used as a buffer/table store by datapath blocks. Both ports share one clock domain.

Parameters:
- DATA_WIDTH, 96: word width in bits; must be a multiple of BYTE_W.
- ADDR_WIDTH, 10: address width; depth = 2**ADDR_WIDTH.
- BYTE_W, 8: bits per write-enable lane; NB = DATA_WIDTH/BYTE_W.
- RD_LATENCY, 2: read latency in cycles; legal values 1 or 2 only.
- WRITE_FIRST, 0: cross-port read-during-write. 1 returns new data; 0 returns old data.
- CLEAR_ON_RESET, 1: 1 runs the zero-fill sweep after reset; 0 makes the RAM ready immediately, contents undefined.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  port A request enable.
- wea  in  NB  port A byte write enables; all-zero with ena=1 is a read.
- addra  in  ADDR_WIDTH  port A address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data, registered.
- douta_vld  out  1  port A read data valid, one-cycle pulse per read.
- enb, web, addrb, dinb, doutb, doutb_vld: port B equivalents of the port A signals.
- init_done  out  1  high when the RAM accepts requests.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle.

Behaviour:
- Reset values: douta/doutb=0, douta_vld/doutb_vld=0, collision=0, init_done=0. All read pipeline registers are cleared.
- State machine has two states, CLEAR and READY.
  - rst forces CLEAR with clr_addr=0, or READY if CLEAR_ON_RESET=0. In that case init_done=1 from the first cycle after rst falls.
  - CLEAR: each cycle writes 0 to mem[clr_addr], then clr_addr++. After writing address 2**ADDR_WIDTH-1, go to READY.
  - init_done rises on the cycle after the last clear write: 2**ADDR_WIDTH cycles after rst deasserts.
  - READY: stays there until rst.
  - rst asserted mid-CLEAR restarts the sweep from address 0.
- While init_done=0, port requests are ignored: no write, no vld pulse.
- Port read (en=1, we=0): mem[addr] appears on dout with dout_vld=1 exactly RD_LATENCY cycles later.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Port write (en=1, we!=0): only byte lanes with we[i]=1 are updated; other lanes are unchanged. A write produces no vld pulse.
- dout holds its last read value until the next valid read. dout_vld is 0 in every cycle with no read result.
- Same-cycle cross-port read/write to the same address:
  - WRITE_FIRST=1: the reader gets the post-write merged word.
  - WRITE_FIRST=0: the reader gets the pre-write word.
- Both ports write the same address in the same cycle:
  - Lanes enabled by both ports take port A's data.
  - Lanes enabled by only one port take that port's data.
  - collision=1 on the next cycle, for one cycle only.
- Both ports reading the same address is legal; both return identical data.
- Address wrap: none. Addresses are exactly ADDR_WIDTH bits, so every value is a valid location.

Optional Feature:
- Macro: BRAM_TDP_PARITY_EN.
- When defined, one even-parity bit per byte lane is stored alongside the data. The parity bit is written whenever its lane is written, including by the clear sweep.
- On each read, parity is recomputed. Two outputs are added: perr_a and perr_b, each 1 bit, valid with dout_vld, and 0 after reset.
- A mismatch on any lane asserts the port's perr in the same cycle as its dout_vld.
- When the macro is undefined, no parity storage exists and the perr ports are absent.

Test Plan:
- Clear sweep: ADDR_WIDTH=4, rst high 3 cycles then low → init_done rises exactly 16 cycles later. Reads of addresses 0..15 return 0.
- Latency: RD_LATENCY=2, write 0xA5A5 to addr 3 on port A, read addr 3 on port B → doutb=0xA5A5 with doutb_vld=1 two cycles after the read request. Repeat with RD_LATENCY=1 → result after one cycle.
- Byte enables: DATA_WIDTH=32, write 0x11223344 to addr 5, then wea=4'b0101 with 0xAABBCCDD → readback 0x11BB33DD.
- Read-during-write: addr 7 holds 0x1, port A writes 0x2 while port B reads addr 7 in the same cycle → doutb=0x1 with WRITE_FIRST=0, doutb=0x2 with WRITE_FIRST=1.
- Collision: port A writes 0xF0 (all lanes) and port B writes 0x0F (all lanes) to addr 9 in the same cycle → collision pulses one cycle; readback 0xF0.
- Mid-clear reset and ignore: assert rst at clear address 8 → sweep restarts at 0 and init_done is delayed accordingly. A port A write issued during CLEAR has no effect: readback after init is 0.
